// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed ternary-input FIR: one shared add/subtract tap datapath steps
// through all coefficients, one tap per enabled cycle, for each accepted sample.
module fir_seq_ctrl #(
    parameter int N_TAPS = 16,
    parameter int COEF_W = 9,
    parameter int ACC_W  = 9,
    parameter int AW     = $clog2(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [1:0]        x,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic [ACC_W-1:0]  y,
    output logic              y_valid,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic [1:0]               hist_q [N_TAPS];
    logic signed [COEF_W-1:0] coef_q [N_TAPS];

    logic signed [ACC_W-1:0]  term_w;
    logic                     accept;
    logic                     coef_wr;
    logic                     last_tap;

    // Ternary tap: +c, -c or 0; coefficient sign-extended (or truncated) to ACC_W.
    function automatic logic signed [ACC_W-1:0] tap_term(
        input logic [1:0]               s,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [ACC_W-1:0] ce;
        ce = ACC_W'(c);
        case (s)
            2'b01:   return ce;
            2'b11:   return -ce;
            default: return '0;
        endcase
    endfunction

    assign term_w   = tap_term(hist_q[idx_q], coef_q[idx_q]);
    assign last_tap = (idx_q == AW'(N_TAPS - 1));
    assign accept   = (state_q == IDLE) && clk_en && x_valid;
    assign coef_wr  = coef_we && clk_en && (state_q == IDLE) && (int'(coef_addr) < N_TAPS);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (clk_en) begin
                    acc_d = acc_q + term_w;
                    idx_d = idx_q + AW'(1);
                    if (last_tap) begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        y_d       = acc_q + term_w;
                        y_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                hist_q[k] <= 2'b00;
                coef_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            if (accept) begin
                hist_q[0] <= x;
                for (int k = 1; k < N_TAPS; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            // A write on the accept edge lands before the first tap reads it.
            if (coef_wr) begin
                coef_q[coef_addr] <= $signed(coef_wdata);
            end
        end
    end

    assign x_ready = (state_q == IDLE) && clk_en;
    assign busy    = (state_q == RUN);
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a dot-product reference model.
module tb_fir_seq_ctrl;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic [1:0] x = 2'b00;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [8:0] coef_wdata = '0;
    logic [8:0] y;
    logic       y_valid;
    logic       busy;

    fir_seq_ctrl #(.N_TAPS(N), .COEF_W(9), .ACC_W(9)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .y(y), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: sample history and coefficients as plain integers; a run is a
    // countdown of N enabled edges ending in y = sum(hist[k]*coef[k]) mod 512.
    int         mhist [N];
    int         mcoef [N];
    bit         m_busy = 0;
    bit         m_yv = 0;
    bit         m_init = 0;
    int         m_cnt = 0;
    int         m_sum;
    logic [8:0] m_y = '0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mhist[k] = 0;
                mcoef[k] = 0;
            end
            m_busy = 0; m_yv = 0; m_y = '0; m_cnt = 0; m_init = 1;
        end else if (!clk_en) begin
            m_yv = 0;
        end else begin
            m_yv = 0;
            if (!m_busy) begin
                if (coef_we && int'(coef_addr) < N) mcoef[coef_addr] = int'($signed(coef_wdata));
                if (x_valid) begin
                    for (int k = N - 1; k > 0; k--) mhist[k] = mhist[k-1];
                    mhist[0] = (x == 2'b01) ? 1 : (x == 2'b11) ? -1 : 0;
                    m_busy = 1;
                    m_cnt = N;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_sum = 0;
                    for (int k = 0; k < N; k++) m_sum += mhist[k] * mcoef[k];
                    m_y = m_sum[8:0];
                    m_yv = 1;
                    m_busy = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check("y_valid", int'(y_valid), int'(m_yv));
            check("y", int'(y), int'(m_y));
            check("busy", int'(busy), int'(m_busy));
            check("x_ready", int'(x_ready), int'(!m_busy && clk_en));
        end
    end

    task automatic prog(input int addr, input int data);
        coef_we = 1'b1;
        coef_addr = addr[3:0];
        coef_wdata = data[8:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offers one sample (accepted at cycle 0) and waits, bounded, for y_valid.
    // lat = edges from accept to y_valid, or -1 when none arrives.
    task automatic run(input logic [1:0] xv, input int stall_cyc, input int stall_len,
                       input int wr_cyc, input int wr_addr, input int wr_data,
                       input int rst_cyc, output int lat, output int yv, output int xr);
        lat = -1; yv = -1; xr = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            x_valid = (cyc == 0);
            x = xv;
            clk_en = !(stall_len > 0 && cyc >= stall_cyc && cyc < stall_cyc + stall_len);
            coef_we = (cyc == wr_cyc);
            coef_addr = wr_addr[3:0];
            coef_wdata = wr_data[8:0];
            rst = (cyc == rst_cyc);
            @(posedge clk); #1;
            if (y_valid) begin
                lat = cyc; yv = int'(y); xr = int'(x_ready);
                break;
            end
        end
        x_valid = 1'b0; coef_we = 1'b0; clk_en = 1'b1; rst = 1'b0;
    endtask

    int lat, yv, xr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_y", int'(y), 0);
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_x_ready", int'(x_ready), 1);
        rst = 1'b0;

        // Impulse response with coef[k] = k+1, back-to-back samples.
        for (int k = 0; k < N; k++) prog(k, k + 1);
        for (int i = 0; i < N; i++) begin
            run((i == 0) ? 2'b01 : 2'b00, -1, 0, -1, 0, 0, -1, lat, yv, xr);
            check("impulse_y", yv, i + 1);
            check("impulse_latency", lat, 16);
            check("impulse_x_ready", xr, 1);
        end

        // Sign handling.
        for (int k = 0; k < N; k++) prog(k, (k == 0) ? 5 : 0);
        run(2'b11, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("sign_neg", yv, 'h1FB);
        run(2'b10, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("sign_zero10", yv, 0);
        run(2'b00, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("sign_zero00", yv, 0);

        // Wrap-around without saturation.
        for (int k = 0; k < N; k++) prog(k, 255);
        for (int i = 0; i < N; i++) run(2'b01, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("wrap_y", yv, 'h1F0);

        // Write during RUN is ignored; write on the accept edge applies.
        do_reset();
        for (int k = 0; k < N; k++) prog(k, k + 1);
        run(2'b01, -1, 0, 5, 3, 100, -1, lat, yv, xr);
        check("wr_run_y0", yv, 1);
        run(2'b00, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        run(2'b00, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        run(2'b00, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("wr_busy_ignored", yv, 4);
        run(2'b00, -1, 0, 0, 4, 77, -1, lat, yv, xr);
        check("wr_on_accept", yv, 77);

        // clk_en stall of 3 cycles mid-run.
        run(2'b00, 5, 3, -1, 0, 0, -1, lat, yv, xr);
        check("stall_latency", lat, 19);
        check("stall_y", yv, 6);

        // Reset at the edge processing tap 7.
        run(2'b00, -1, 0, -1, 0, 0, 8, lat, yv, xr);
        check("rst_no_y_valid", lat, -1);
        check("rst_y", int'(y), 0);
        check("rst_busy", int'(busy), 0);
        run(2'b01, -1, 0, -1, 0, 0, -1, lat, yv, xr);
        check("rst_coefs_cleared", yv, 0);
        check("rst_latency", lat, 16);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            x_valid = ($urandom_range(0, 2) == 0);
            x = 2'($urandom);
            coef_we = ($urandom_range(0, 3) == 0);
            coef_addr = 4'($urandom);
            coef_wdata = 9'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            @(posedge clk); #1;
        end
        x_valid = 1'b0; coef_we = 1'b0; clk_en = 1'b1; rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Time-multiplexed FIR sequencer for the FSK demodulator. It holds an N-tap ternary sample delay line and a programmable coefficient bank. For each accepted sample it steps one shared add/subtract tap datapath through all coefficients, one tap per enabled clock cycle. It replaces a fully unrolled tap chain where area matters more than throughput, and it produces the same modulo-2^ACC_W result as that chain.

## Interface
Parameters:
- N_TAPS, 16: number of taps; power of two, ≥2.
- COEF_W, 9: signed coefficient width.
- ACC_W, 9: accumulator/output width; arithmetic is modulo 2^ACC_W.
- AW, $clog2(N_TAPS): coefficient address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  global enable; when low, all state is frozen.
- x  in  2  ternary sample: 2'b01 = +1, 2'b11 = −1, 2'b00/2'b10 = 0.
- x_valid  in  1  sample offered.
- x_ready  out  1  = (state==IDLE) && clk_en; sample accepted on an edge with x_valid && x_ready.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index.
- coef_wdata  in  COEF_W  signed coefficient value.
- y  out  ACC_W  filter output, registered, held between results.
- y_valid  out  1  one-cycle pulse marking a new y.
- busy  out  1  = (state==RUN).

## Operation
- FSM states:
  - IDLE → RUN on sample accept.
  - RUN → IDLE on the enabled edge that processes tap N_TAPS−1.
- Accept edge, in IDLE with clk_en=1 and x_valid=1:
  - hist[0] ← x; hist[k] ← hist[k−1] for k=1..N_TAPS−1.
  - idx ← 0; acc ← 0; state ← RUN.
- RUN, each edge with clk_en=1: acc ← acc + term(hist[idx], coef[idx]); idx ← idx+1.
- term encoding:
  - 01 → +sext(coef).
  - 11 → −sext(coef).
  - 00/10 → 0.
- Coefficients are sign-extended to ACC_W, or truncated if ACC_W < COEF_W. Sums wrap silently, with no saturation.
- Last tap (idx = N_TAPS−1) on an enabled edge:
  - y ← acc + term.
  - y_valid ← 1 for exactly one cycle.
  - state ← IDLE; idx ← 0.
- Coefficient write:
  - On an edge with coef_we=1, clk_en=1, state==IDLE: coef[coef_addr] ← coef_wdata.
  - Ignored when busy, when clk_en=0, or when coef_addr ≥ N_TAPS.
- Simultaneous coef_we and sample accept in IDLE: both take effect. The run uses the newly written coefficient.
- clk_en=0 holds everything:
  - FSM, idx, acc and hist are frozen.
  - y_valid is cleared.
  - No accept and no writes take place.
- x is sampled only on the accept edge. x_valid while busy is ignored and not queued.

## Timing
- Reset values:
  - state=IDLE, idx=0, acc=0.
  - hist all 2'b00, coef all 0.
  - y=0, y_valid=0, busy=0.
  - x_ready equals clk_en, since it is combinational from IDLE.
  - While rst=1, x_valid and coef_we are ignored.
- Latency, with clk_en held high:
  - Accept at edge E0; tap k is processed at edge E(k+1).
  - y and y_valid update at edge E(N_TAPS).
  - y_valid is high in the cycle after E(N_TAPS).
- x_ready is high again in the same cycle as y_valid. A back-to-back accept on that edge is allowed, giving a throughput of 1 sample per N_TAPS+1 cycles.
- Each clk_en=0 cycle during RUN adds exactly one cycle of latency.
- rst asserted mid-RUN:
  - Aborts the run on that edge; no y_valid follows.
  - hist and coefficients are cleared.
  - y returns to 0.

## Test plan
- Impulse response:
  - Stimulus: N_TAPS=16, coef[k]=k+1; send 01, then fifteen 00 samples back-to-back.
  - Response: y sequence 1,2,…,16.
  - Check: each y_valid comes exactly 16 cycles after its accept, and x_ready is high in the y_valid cycle.
- Sign handling:
  - Stimulus: coef[0]=5, other coefs 0; send 11.
  - Response: y=9'h1FB (−5).
  - Follow-up: send 10, then 00; both give y=0.
- Wrap-around:
  - Stimulus: all coef=255; send sixteen 01 samples.
  - Response: the 16th result y=9'h1F0 (4080 mod 512, i.e. −16), with no saturation.
- Write rules:
  - coef_we during RUN (coef[3]=100) is ignored; the next impulse run still shows the old coef[3].
  - coef_we with coef_addr ≥ N_TAPS is ignored.
  - coef_we concurrent with accept applies to that run.
- clk_en stall:
  - Stimulus: drop clk_en for 3 cycles mid-RUN.
  - Response: y_valid arrives 3 cycles later with an unchanged value; x_ready is low while clk_en=0.
- Reset mid-run:
  - Stimulus: rst at tap 7.
  - Response: no y_valid; y=0; busy=0 next cycle; a subsequent impulse with unprogrammed coefficients yields y=0.
